// File: rtl/ps2_cmd_ctrl_pkg.sv
// Shared constants for the PS/2 command controller: command codes, scan-code
// prefixes, prefix-FSM state encoding and the level reset value.
package ps2_cmd_ctrl_pkg;

  localparam logic [3:0] CMD_R1     = 4'h0;
  localparam logic [3:0] CMD_R2     = 4'h1;
  localparam logic [3:0] CMD_R3     = 4'h2;
  localparam logic [3:0] CMD_R4     = 4'h3;
  localparam logic [3:0] CMD_CH_R   = 4'h4;
  localparam logic [3:0] CMD_CH_G   = 4'h5;
  localparam logic [3:0] CMD_CH_B   = 4'h6;
  localparam logic [3:0] CMD_UP     = 4'h7;
  localparam logic [3:0] CMD_DOWN   = 4'h8;
  localparam logic [3:0] CMD_LEFT   = 4'h9;
  localparam logic [3:0] CMD_RIGHT  = 4'hA;
  localparam logic [3:0] CMD_PLUS   = 4'hB;
  localparam logic [3:0] CMD_MINUS  = 4'hC;
  localparam logic [3:0] CMD_FREEZE = 4'hD;
  localparam logic [3:0] CMD_NONE   = 4'hE;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [3:0] LEVEL_RST = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

endpackage

// File: rtl/ps2_cmd_ctrl_if.sv
// Byte-stream input and display-configuration outputs of the command controller.
interface ps2_cmd_ctrl_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          codeValid;
  logic [7:0]    codeIn;
  logic          cmdValid;
  logic [3:0]    cmdCode;
  logic [1:0]    regionSel;
  logic [1:0]    chanSel;
  logic [3:0]    levelR;
  logic [3:0]    levelG;
  logic [3:0]    levelB;
  logic [XW-1:0] cursorX;
  logic [YW-1:0] cursorY;
  logic          freeze;

  modport master (
    output codeValid, codeIn,
    input  cmdValid, cmdCode, regionSel, chanSel, levelR, levelG, levelB,
           cursorX, cursorY, freeze
  );

  modport slave (
    input  codeValid, codeIn,
    output cmdValid, cmdCode, regionSel, chanSel, levelR, levelG, levelB,
           cursorX, cursorY, freeze
  );
endinterface

// File: rtl/ps2_code_map.sv
// Combinational scan-code to command translation; CMD_NONE marks unmapped keys.
module ps2_code_map
  import ps2_cmd_ctrl_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output logic [3:0] o_cmd
);

  always_comb begin
    // NOTE: default first, so no path through the case leaves o_cmd unassigned (no latch).
    o_cmd = CMD_NONE;
    case ({i_ext, i_code})
      9'h016: o_cmd = CMD_R1;
      9'h01E: o_cmd = CMD_R2;
      9'h026: o_cmd = CMD_R3;
      9'h025: o_cmd = CMD_R4;
      9'h02D: o_cmd = CMD_CH_R;
      9'h034: o_cmd = CMD_CH_G;
      9'h032: o_cmd = CMD_CH_B;
      9'h079: o_cmd = CMD_PLUS;
      9'h07B: o_cmd = CMD_MINUS;
      9'h02B: o_cmd = CMD_FREEZE;
      9'h175: o_cmd = CMD_UP;
      9'h172: o_cmd = CMD_DOWN;
      9'h16B: o_cmd = CMD_LEFT;
      9'h174: o_cmd = CMD_RIGHT;
      default: o_cmd = CMD_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// Prefix FSM, repeat suppression and saturating display-configuration registers
// driven by PS/2 scan-code bytes.
module ps2_cmd_ctrl
  import ps2_cmd_ctrl_pkg::*;
#(
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479,
  parameter int STEP  = 8,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input logic           clk,
  input logic           reset,
  ps2_cmd_ctrl_if.slave bus
);

  state_t        r_state, w_state_nxt;
  logic [8:0]    r_held;
  logic          r_cmd_valid;
  logic [3:0]    r_cmd_code;
  logic [1:0]    r_region, r_chan;
  logic [3:0]    r_lvl_r, r_lvl_g, r_lvl_b;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_freeze;

  logic          w_make, w_break, w_ext, w_fire, w_mapped;
  logic [3:0]    w_cmd;
  logic [8:0]    w_key;

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    w_ext       = 1'b0;
    if (bus.codeValid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.codeIn == PFX_EXT)      w_state_nxt = ST_EXT;
          else if (bus.codeIn == PFX_BRK) w_state_nxt = ST_BRK;
          else                            w_make = 1'b1;
        end
        ST_EXT: begin
          w_ext = 1'b1;
          if (bus.codeIn == PFX_BRK)      w_state_nxt = ST_EXT_BRK;
          else if (bus.codeIn != PFX_EXT) begin
            w_make      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_ext = (r_state == ST_EXT_BRK);
          if (bus.codeIn != PFX_BRK) begin
            w_break     = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_key = {w_ext, bus.codeIn};

  ps2_code_map u_map (
    .i_ext  (w_ext),
    .i_code (bus.codeIn),
    .o_cmd  (w_cmd)
  );

  // Typematic repeats of the level keys pass; any other repeated make is dropped.
  assign w_mapped = (w_cmd != CMD_NONE);
  assign w_fire   = w_make && w_mapped &&
                    ((w_key != r_held) || (w_cmd == CMD_PLUS) || (w_cmd == CMD_MINUS));

  logic [XW:0] w_x_add, w_x_sub;
  logic [YW:0] w_y_add, w_y_sub;
  logic [XW-1:0] w_x_inc, w_x_dec;
  logic [YW-1:0] w_y_inc, w_y_dec;
  logic [3:0]    w_lvl_cur, w_lvl_inc, w_lvl_dec;
  logic [4:0]    w_lvl_add;

  assign w_x_add = {1'b0, r_x} + (XW+1)'(STEP);
  assign w_x_sub = {1'b0, r_x} - (XW+1)'(STEP);
  assign w_y_add = {1'b0, r_y} + (YW+1)'(STEP);
  assign w_y_sub = {1'b0, r_y} - (YW+1)'(STEP);
  assign w_x_inc = (w_x_add > (XW+1)'(X_MAX)) ? XW'(X_MAX) : w_x_add[XW-1:0];
  assign w_y_inc = (w_y_add > (YW+1)'(Y_MAX)) ? YW'(Y_MAX) : w_y_add[YW-1:0];
  assign w_x_dec = w_x_sub[XW] ? '0 : w_x_sub[XW-1:0];
  assign w_y_dec = w_y_sub[YW] ? '0 : w_y_sub[YW-1:0];

  assign w_lvl_cur = (r_chan == 2'd1) ? r_lvl_g : (r_chan == 2'd2) ? r_lvl_b : r_lvl_r;
  assign w_lvl_add = {1'b0, w_lvl_cur} + 5'd1;
  assign w_lvl_inc = w_lvl_add[4] ? 4'd15 : w_lvl_add[3:0];
  assign w_lvl_dec = (w_lvl_cur == 4'd0) ? 4'd0 : w_lvl_cur - 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_held  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of its peers.
      r_state <= w_state_nxt;
      if (w_make && w_mapped)                 r_held <= w_key;
      else if (w_break && (w_key == r_held))  r_held <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= CMD_NONE;
      r_region    <= '0;
      r_chan      <= '0;
      r_lvl_r     <= LEVEL_RST;
      r_lvl_g     <= LEVEL_RST;
      r_lvl_b     <= LEVEL_RST;
      r_x         <= '0;
      r_y         <= '0;
      r_freeze    <= 1'b0;
    end else begin
      r_cmd_valid <= w_fire;
      if (w_fire) begin
        r_cmd_code <= w_cmd;
        case (w_cmd)
          CMD_R1, CMD_R2, CMD_R3, CMD_R4: r_region <= w_cmd[1:0];
          CMD_CH_R:   r_chan   <= 2'd0;
          CMD_CH_G:   r_chan   <= 2'd1;
          CMD_CH_B:   r_chan   <= 2'd2;
          CMD_FREEZE: r_freeze <= ~r_freeze;
          CMD_UP:     if (!r_freeze) r_y <= w_y_dec;
          CMD_DOWN:   if (!r_freeze) r_y <= w_y_inc;
          CMD_LEFT:   if (!r_freeze) r_x <= w_x_dec;
          CMD_RIGHT:  if (!r_freeze) r_x <= w_x_inc;
          CMD_PLUS, CMD_MINUS: if (!r_freeze) begin
            case (r_chan)
              2'd1:    r_lvl_g <= (w_cmd == CMD_PLUS) ? w_lvl_inc : w_lvl_dec;
              2'd2:    r_lvl_b <= (w_cmd == CMD_PLUS) ? w_lvl_inc : w_lvl_dec;
              default: r_lvl_r <= (w_cmd == CMD_PLUS) ? w_lvl_inc : w_lvl_dec;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cmdValid  = r_cmd_valid;
  assign bus.cmdCode   = r_cmd_code;
  assign bus.regionSel = r_region;
  assign bus.chanSel   = r_chan;
  assign bus.levelR    = r_lvl_r;
  assign bus.levelG    = r_lvl_g;
  assign bus.levelB    = r_lvl_b;
  assign bus.cursorX   = r_x;
  assign bus.cursorY   = r_y;
  assign bus.freeze    = r_freeze;

endmodule

// File: doc/ps2_cmd_ctrl.md
# ps2_cmd_ctrl

Sequencing controller between the PS/2 byte receiver and the VGA pattern/colour logic. Consumes raw scan-code bytes, tracks make/break/extended prefixes and typematic repeats, maps completed key presses to 4-bit command codes, and applies them to the display configuration registers: region, channel, RGB levels, cursor and freeze. All outputs are registered.

## Interface
- X_MAX, 639, largest cursor X value
- Y_MAX, 479, largest cursor Y value
- STEP, 8, cursor increment per arrow press
- XW, 10, cursor X width
- YW, 9, cursor Y width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- codeValid  in  1  one-cycle strobe, codeIn holds a received byte
- codeIn  in  8  scan-code byte
- cmdValid  out  1  one-cycle pulse per accepted command
- cmdCode  out  4  command of last pulse (0–3 region 1–4, 4 R, 5 G, 6 B, 7 up, 8 down, 9 left, A right, B +, C −, D freeze toggle, E none)
- regionSel  out  2  selected screen region
- chanSel  out  2  selected channel (0 R, 1 G, 2 B)
- levelR / levelG / levelB  out  4 each  channel intensities
- cursorX  out  XW  cursor column
- cursorY  out  YW  cursor row
- freeze  out  1  configuration lock

## Operation
- Prefix FSM: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0). Bytes are processed only on codeValid.
  - IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte is a make.
  - EXT: F0 goes to EXT_BRK. E0 stays in EXT. Any other byte is an extended make.
  - BRK / EXT_BRK: F0 stays. Any other byte is a break (extended break from EXT_BRK). Return to IDLE.
  - After any make, return to IDLE.
- Map, normal: 16→0, 1E→1, 26→2, 25→3, 2D→4, 34→5, 32→6, 79→B, 7B→C, 2B→D.
- Map, extended: 75→7, 72→8, 6B→9, 74→A.
- Any other byte, E1 included, is unmapped. It produces no pulse, and the FSM returns to IDLE.
- Repeat suppression: register held = {ext, code}.
  - A mapped make equal to held is suppressed, except cmdCode B and C (typematic allowed).
  - Every mapped make loads held.
  - A break matching held clears held to 0.
  - Breaks never pulse.
- Command effects, applied on the pulse cycle:
  - 0–3: regionSel ← n.
  - 4–6: chanSel ← 0/1/2.
  - D: freeze toggles.
  - These apply regardless of freeze.
  - 7/8: cursorY −/+ STEP, saturating at 0 and Y_MAX. Ignored while freeze=1.
  - 9/A: cursorX −/+ STEP, saturating at 0 and X_MAX. Ignored while freeze=1.
  - B/C: the level of chanSel +1/−1, saturating at 15 and 0. Ignored while freeze=1.
- cmdValid still pulses for commands ignored by freeze. cmdCode holds its value between pulses.
- Reset values:
  - cmdValid 0, cmdCode E.
  - regionSel 0, chanSel 0.
  - levelR/G/B 8.
  - cursor (0,0).
  - freeze 0.
  - FSM IDLE, held 0.

## Timing
- Latency: a make byte strobed at cycle N gives cmdValid=1 and updated config registers at N+1.
- Back-to-back codeValid strobes on consecutive cycles are all processed. There is no backpressure.
- Saturation arithmetic is computed one bit wider, then clamped. Example: cursorX=636, STEP=8 → 639.
- Reset asserted mid-sequence (e.g. after E0) returns to IDLE. The next non-prefix byte after release is a normal make.
- codeValid during reset is ignored.

## Structure
- Shared package: command-code constants (CMD_R1 … CMD_NONE), prefix constants (8'hE0, 8'hF0), FSM state encoding, level reset value.
- One sub-module, ps2_code_map: purely combinational {ext, code} → 4-bit command (E = unmapped). Instantiated once.
- Top holds the FSM, held register, and the saturating config datapath.

## Test plan
- Reset, then strobe 1E → next cycle cmdValid=1, cmdCode=1, regionSel=1. Then F0,1E → no pulse, held cleared.
- 34, F0 34, 79 ×9 (typematic, no break) → chanSel=1, levelG=15 (8 +7, saturates), 9 pulses. Then 7B → levelG=14.
- E0 74 ×80 with break between each → cursorX=639 (saturated), cmdCode=A. Then E0 6B → cursorX=631.
- 2B then E0 72 → freeze=1, cmdValid pulses, cursorY unchanged at 0. Then 26 → regionSel=2 despite freeze.
- 16 twice without break → one pulse only. Then F0 16, 16 → second pulse.
- E0 then reset pulse, then 6B → cmdValid pulse with cmdCode=9? No: 6B is normal make and unmapped → no pulse, all registers at reset values.
